// File: rtl/math_calculator_fsm_if.sv
// Keypad/display bus for the calculator controller: the scan code in,
// decoded key fields and the two Q8.8 display values out.
interface math_calculator_fsm_if;
  logic [7:0]  button;
  logic        clear;
  logic [3:0]  button_num;
  logic [2:0]  button_op;
  logic        equal;
  logic [15:0] result_temp;
  logic [15:0] result;

  // Keypad scanner / display driver side
  modport master (
    output button,
    input  clear, button_num, button_op, equal, result_temp, result
  );

  // Calculator side
  modport slave (
    input  button,
    output clear, button_num, button_op, equal, result_temp, result
  );
endinterface

// File: rtl/math_calculator_fsm.sv
// Four-function keypad calculator controller. Decodes 4x4 keypad scan
// codes, edge-detects presses, accumulates operands and chains operations
// left-to-right in signed Q8.8.
module math_calculator_fsm #(
  parameter int FRAC_BITS = 8,
  parameter int MAX_INT   = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  math_calculator_fsm_if.slave  bus
);

  typedef enum logic [1:0] {S_OP1, S_OPSEL, S_OP2, S_RESULT} state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  state_t      state;
  logic [7:0]  prev_button;
  logic [15:0] acc;
  logic [15:0] entry;
  logic [2:0]  pend_op;
  logic [15:0] result_temp_q;
  logic [15:0] result_q;

  logic        is_clear;
  logic        is_equal;
  logic [3:0]  num;
  logic [2:0]  op;
  logic        is_digit;
  logic        is_op;
  logic        press;
  logic [10:0] new_int;
  logic [15:0] entry_dig;
  logic [15:0] digit_q;
  logic [15:0] calc_val;

  // Key decode: digit value, operator code and control keys
  always_comb begin
    num = 4'hF;
    op  = OP_NONE;
    unique case (bus.button)
      8'h14: num = 4'd0;
      8'h05: num = 4'd1;
      8'h15: num = 4'd2;
      8'h25: num = 4'd3;
      8'h06: num = 4'd4;
      8'h16: num = 4'd5;
      8'h26: num = 4'd6;
      8'h07: num = 4'd7;
      8'h17: num = 4'd8;
      8'h27: num = 4'd9;
      8'h37: op  = OP_ADD;
      8'h36: op  = OP_SUB;
      8'h35: op  = OP_MUL;
      8'h34: op  = OP_DIV;
      default: ;
    endcase
  end

  assign is_clear = (bus.button == 8'h04);
  assign is_equal = (bus.button == 8'h24);
  assign is_digit = (num != 4'hF);
  assign is_op    = (op != OP_NONE);
  assign press    = (prev_button == 8'h00) && (is_clear || is_equal || is_digit || is_op);

  assign bus.clear       = is_clear;
  assign bus.equal       = is_equal;
  assign bus.button_num  = num;
  assign bus.button_op   = op;
  assign bus.result_temp = result_temp_q;
  assign bus.result      = result_q;

  // Signed Q8.8 arithmetic on acc and entry
  function automatic logic [15:0] calc(input logic [15:0] a, input logic [2:0] f,
                                       input logic [15:0] b);
    logic signed [31:0] sa, sb, prod;
    logic signed [23:0] dnum, dden, quo;
    sa   = {{16{a[15]}}, a};
    sb   = {{16{b[15]}}, b};
    prod = sa * sb;
    dnum = {a, 8'h00};
    dden = {{8{b[15]}}, b};
    quo  = '0;
    if (b != 16'h0000) quo = dnum / dden;
    calc = b;
    unique case (f)
      OP_ADD: calc = a + b;
      OP_SUB: calc = a - b;
      OP_MUL: calc = prod[23:8];
      OP_DIV: begin
        if (b == 16'h0000) calc = a[15] ? 16'h8000 : 16'h7FFF;
        else               calc = quo[15:0];
      end
      default: calc = b;
    endcase
  endfunction

  // Operand entry values: next multi-digit entry, single-digit entry, and result of f
  always_comb begin
    new_int   = 11'(entry[15:FRAC_BITS]) * 11'd10 + 11'(num);
    entry_dig = entry;
    if (new_int <= 11'(MAX_INT)) entry_dig = 16'(new_int) << FRAC_BITS;
    digit_q   = 16'(num) << FRAC_BITS;
    calc_val  = calc(acc, pend_op, entry);
  end

  // Calculator FSM with registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_button   <= 8'h00;
      state         <= S_OP1;
      acc           <= '0;
      entry         <= '0;
      pend_op       <= OP_NONE;
      result_temp_q <= '0;
      result_q      <= '0;
    end else begin
      prev_button <= bus.button;
      if (press) begin
        if (is_clear) begin
          state         <= S_OP1;
          acc           <= '0;
          entry         <= '0;
          pend_op       <= OP_NONE;
          result_temp_q <= '0;
          result_q      <= '0;
        end else begin
          unique case (state)
            S_OP1: begin
              if (is_digit) begin
                entry         <= entry_dig;
                result_temp_q <= entry_dig;
              end else if (is_op) begin
                acc     <= entry;
                pend_op <= op;
                state   <= S_OPSEL;
              end else if (is_equal) begin
                acc      <= entry;
                result_q <= entry;
                state    <= S_RESULT;
              end
            end
            S_OPSEL: begin
              if (is_digit) begin
                entry         <= digit_q;
                result_temp_q <= digit_q;
                state         <= S_OP2;
              end else if (is_op) begin
                pend_op <= op;
              end else if (is_equal) begin
                result_q <= acc;
                state    <= S_RESULT;
              end
            end
            S_OP2: begin
              if (is_digit) begin
                entry <= entry_dig;
              end else if (is_op) begin
                acc           <= calc_val;
                result_temp_q <= calc_val;
                pend_op       <= op;
                state         <= S_OPSEL;
              end else if (is_equal) begin
                acc           <= calc_val;
                result_q      <= calc_val;
                result_temp_q <= calc_val;
                state         <= S_RESULT;
              end
            end
            S_RESULT: begin
              if (is_op) begin
                pend_op <= op;
                state   <= S_OPSEL;
              end else if (is_digit) begin
                entry         <= digit_q;
                result_temp_q <= digit_q;
                state         <= S_OP1;
              end
            end
            default: state <= S_OP1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_math_calculator_fsm.sv
// Directed bench for math_calculator_fsm: key sequences with hand-computed
// Q8.8 results.
module tb_math_calculator_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  math_calculator_fsm_if bus ();

  math_calculator_fsm #(.FRAC_BITS(8), .MAX_INT(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] K0 = 8'h14, K1 = 8'h05, K2 = 8'h15, K3 = 8'h25;
  localparam logic [7:0] K5 = 8'h16, K6 = 8'h26, K7 = 8'h07, K8 = 8'h17, K9 = 8'h27;
  localparam logic [7:0] KADD = 8'h37, KSUB = 8'h36, KMUL = 8'h35, KDIV = 8'h34;
  localparam logic [7:0] KEQ = 8'h24, KCLR = 8'h04;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle press followed by one-cycle release
  task automatic press(input logic [7:0] code);
    @(negedge clk) bus.button = code;
    @(negedge clk) bus.button = 8'h00;
  endtask

  initial begin
    bus.button = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Decode outputs (reset held so keys have no effect)
    bus.button = KADD; #1;
    check("op_add_code", 16'(bus.button_op), 16'd1);
    check("op_add_num", 16'(bus.button_num), 16'hF);
    bus.button = K9; #1;
    check("num9", 16'(bus.button_num), 16'd9);
    check("num9_op", 16'(bus.button_op), 16'd0);
    bus.button = KCLR; #1;
    check("clear_flag", 16'(bus.clear), 16'd1);
    bus.button = KEQ; #1;
    check("equal_flag", 16'(bus.equal), 16'd1);
    check("equal_clearflag", 16'(bus.clear), 16'd0);
    @(negedge clk) bus.button = 8'h00;
    check("reset_result", bus.result, 16'h0000);
    check("reset_rtemp", bus.result_temp, 16'h0000);
    rst = 1'b0;

    // 5 + 3 =
    press(K5); check("t1_digit5", bus.result_temp, 16'h0500);
    press(KADD); press(K3);
    check("t1_op2_rtemp", bus.result_temp, 16'h0300);
    press(KEQ);
    check("t1_result", bus.result, 16'h0800);
    check("t1_rtemp", bus.result_temp, 16'h0800);
    press(KCLR);
    check("t1_clr_result", bus.result, 16'h0000);
    check("t1_clr_rtemp", bus.result_temp, 16'h0000);

    // 5 - 3 + 2 =
    press(K5); press(KSUB); press(K3); press(KADD);
    check("t2_chain_rtemp", bus.result_temp, 16'h0200);
    check("t2_result_hold", bus.result, 16'h0000);
    press(K2); press(KEQ);
    check("t2_result", bus.result, 16'h0400);

    // 6 / 3 = then * 8 =
    press(K6);
    check("t3_newcalc_rtemp", bus.result_temp, 16'h0600);
    check("t3_result_holds", bus.result, 16'h0400);
    press(KDIV); press(K3); press(KEQ);
    check("t3_div", bus.result, 16'h0200);
    press(KMUL); press(K8); press(KEQ);
    check("t3_mul_cont", bus.result, 16'h1000);

    // 7 / 2 =
    press(KCLR); press(K7); press(KDIV); press(K2); press(KEQ);
    check("t4_frac_div", bus.result, 16'h0380);
    // 5 / 0 =
    press(KCLR); press(K5); press(KDIV); press(K0); press(KEQ);
    check("t4_div0", bus.result, 16'h7FFF);
    // 0 - 5 =
    press(KCLR); press(K0); press(KSUB); press(K5); press(KEQ);
    check("t4_neg", bus.result, 16'hFB00);
    // -5 / 0 = (continue from -5)
    press(KDIV); press(K0); press(KEQ);
    check("t4_div0_neg", bus.result, 16'h8000);
    // -5 * 2 = -> -10
    press(KCLR); press(K0); press(KSUB); press(K5); press(KMUL); press(K2); press(KEQ);
    check("t4_neg_mul", bus.result, 16'hF600);

    // 12 + 3 =
    press(KCLR); press(K1); press(K2);
    check("t5_twelve", bus.result_temp, 16'h0C00);
    press(KADD); press(K3); press(KEQ);
    check("t5_multi", bus.result, 16'h0F00);
    // Hold 5 for four cycles
    press(KCLR);
    @(negedge clk) bus.button = K5;
    repeat (4) @(negedge clk);
    bus.button = 8'h00;
    @(negedge clk);
    check("t5_hold", bus.result_temp, 16'h0500);
    // 5 then directly 6 without release: only the 5 counts
    press(KCLR);
    @(negedge clk) bus.button = K5;
    @(negedge clk) bus.button = K6;
    @(negedge clk) bus.button = 8'h00;
    @(negedge clk);
    check("t5_no_rollover", bus.result_temp, 16'h0500);
    press(KEQ);
    check("t5_op1_equal", bus.result, 16'h0500);
    // 1 2 8: 128 exceeds the limit
    press(KCLR); press(K1); press(K2); press(K8);
    check("t5_max_reject", bus.result_temp, 16'h0C00);
    // 1 2 7: exactly at the limit
    press(KCLR); press(K1); press(K2); press(K7);
    check("t5_max_accept", bus.result_temp, 16'h7F00);

    // rst together with a key
    press(KCLR); press(K9); press(KMUL); press(K9); press(KEQ);
    check("t6_pre", bus.result, 16'h5100);
    @(negedge clk) begin rst = 1'b1; bus.button = K5; end
    @(negedge clk) begin rst = 1'b0; bus.button = 8'h00; end
    check("t6_rst_result", bus.result, 16'h0000);
    check("t6_rst_rtemp", bus.result_temp, 16'h0000);
    @(negedge clk);
    press(K3); press(KEQ);
    check("t6_after_rst", bus.result, 16'h0300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
